delay_line_writer: RTL

- Write end of a serial recirculating delay line.
- Each bit time holds four interleaved channel slots, W, X, Y, Z (slot 0..3). Per slot the block drives the line's gate input with one of two sources:
  - the recirculated sense-amp bit, or
  - a bit of a new word loaded through a valid/ready handshake.
- It is the producer counterpart of the phase-slot latches that sample the line output. One instance drives each line (44-bit-time and 31-bit-time lines).

---
 rtl/dl_pkg.sv | 23 ++
 rtl/delay_line_writer_if.sv | 16 +
 rtl/dl_chan_shifter.sv | 76 +++++++
 rtl/delay_line_writer.sv | 91 +++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared definitions for the delay line write end: slot and channel-state
// encodings plus the default word length.
package dl_pkg;

  localparam int DL_WORD_BITS = 28;
  localparam int DL_NUM_CH    = 4;

  // Interleaved channel slots within one bit time.
  typedef enum logic [1:0] {
    SLOT_W = 2'd0,
    SLOT_X = 2'd1,
    SLOT_Y = 2'd2,
    SLOT_Z = 2'd3
  } slot_e;

  // Per-channel write progress.
  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_PEND  = 2'd1,
    CH_SHIFT = 2'd2
  } ch_state_e;

endpackage

// File: rtl/delay_line_writer_if.sv
// Valid/ready write request channel into the delay line writer.
interface delay_line_writer_if
  import dl_pkg::*;
#(
  parameter int DATA_W = DL_WORD_BITS
) ();

  logic              wr_valid;
  logic [1:0]        wr_ch;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_ch, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_data, output wr_ready);

endinterface

// File: rtl/dl_chan_shifter.sv
// One channel of the delay line writer: holds the loaded word, waits for the
// channel's bit-0 slot, then offers one bit per owned slot, LSB first.
module dl_chan_shifter
  import dl_pkg::*;
#(
  parameter int WORD_BITS = DL_WORD_BITS,
  parameter int DATA_W    = WORD_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_slot_en,
  input  logic              i_slot_hit,
  input  logic              i_bit_first,
  input  logic              i_bit_last,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_drive,
  output logic              o_bit,
  output logic              o_idle,
  output logic              o_busy,
  output logic              o_done
);

  ch_state_e         r_state;
  logic [DATA_W-1:0] r_shift;
  logic              r_done;
  logic              w_step;

  // The channel owns this slot's gate either while shifting or on the very
  // slot where a pending word starts at bit 0.
  assign o_drive = i_slot_hit &&
                   ((r_state == CH_SHIFT) || ((r_state == CH_PEND) && i_bit_first));
  assign o_bit   = r_shift[0];
  assign o_idle  = (r_state == CH_IDLE);
  assign o_busy  = (r_state != CH_IDLE);
  assign o_done  = r_done;
  assign w_step  = i_slot_en && o_drive;

  // Channel FSM, shift register and the one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is cleared along with the FSM so an aborted
      // word leaves no stale bits behind for the next load.
      r_state <= CH_IDLE;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CH_IDLE: begin
          if (i_load) begin
            r_state <= CH_PEND;
            r_shift <= i_load_data;
          end
        end
        CH_PEND: begin
          if (w_step) begin
            r_state <= CH_SHIFT;
            r_shift <= r_shift >> 1;
          end
        end
        CH_SHIFT: begin
          if (w_step) begin
            r_shift <= r_shift >> 1;
            if (i_bit_last) begin
              r_state <= CH_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/delay_line_writer.sv
// Write end of a serial recirculating delay line. Four interleaved channel
// slots per bit time; each slot's gate bit is either the recirculated sense
// bit or a bit of a word injected through the valid/ready request channel.
module delay_line_writer
  import dl_pkg::*;
#(
  parameter int WORD_BITS = DL_WORD_BITS,
  parameter int NUM_CH    = DL_NUM_CH,
  parameter int DATA_W    = WORD_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                slot_en,
  input  logic                sense_in,
  delay_line_writer_if.slave  wr_if,
  output logic                gate_out,
  output logic [1:0]          slot,
  output logic [4:0]          bit_idx,
  output logic                word_start,
  output logic [NUM_CH-1:0]   ch_busy,
  output logic [NUM_CH-1:0]   wr_done
);

  logic [1:0]        r_slot;
  logic [4:0]        r_bit_idx;
  logic              r_gate;
  logic              w_bit_first;
  logic              w_bit_last;
  logic              w_accept;
  logic [NUM_CH-1:0] w_idle;
  logic [NUM_CH-1:0] w_drive;
  logic [NUM_CH-1:0] w_shift_bit;

  assign w_bit_first    = (r_bit_idx == 5'd0);
  assign w_bit_last     = (r_bit_idx == 5'(WORD_BITS - 1));
  assign wr_if.wr_ready = w_idle[wr_if.wr_ch] && !rst;
  assign w_accept       = wr_if.wr_valid && wr_if.wr_ready;

  assign gate_out   = r_gate;
  assign slot       = r_slot;
  assign bit_idx    = r_bit_idx;
  assign word_start = (r_slot == SLOT_W) && w_bit_first;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dl_chan_shifter #(
      .WORD_BITS (WORD_BITS),
      .DATA_W    (DATA_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .i_slot_en   (slot_en),
      .i_slot_hit  (r_slot == 2'(g)),
      .i_bit_first (w_bit_first),
      .i_bit_last  (w_bit_last),
      .i_load      (w_accept && (wr_if.wr_ch == 2'(g))),
      .i_load_data (wr_if.wr_data),
      .o_drive     (w_drive[g]),
      .o_bit       (w_shift_bit[g]),
      .o_idle      (w_idle[g]),
      .o_busy      (ch_busy[g]),
      .o_done      (wr_done[g])
    );
  end

  // Slot and bit-time counters; bit_idx advances when the slot wraps.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge counter values, independent of block ordering.
    if (rst) begin
      r_slot    <= SLOT_W;
      r_bit_idx <= '0;
    end else if (slot_en) begin
      if (r_slot == 2'(NUM_CH - 1)) begin
        r_slot    <= SLOT_W;
        r_bit_idx <= w_bit_last ? 5'd0 : r_bit_idx + 5'd1;
      end else begin
        r_slot <= r_slot + 2'd1;
      end
    end
  end

  // Gate mux: the owning channel's shift bit, otherwise recirculate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate <= 1'b0;
    end else if (slot_en) begin
      r_gate <= w_drive[r_slot] ? w_shift_bit[r_slot] : sense_in;
    end
  end

endmodule
